// File: rtl/pyramid_pkg.sv
// Shared types and helpers for the 2x2 pyramid decimator.
package pyramid_pkg;

    // Line-pairing state of the decimator
    typedef enum logic [1:0] {
        WAIT_FRAME = 2'd0,
        EVEN_LINE  = 2'd1,
        ODD_LINE   = 2'd2
    } pyr_state_e;

    // Four DATA_W pixels need two extra bits to sum without loss
    function automatic int unsigned sum_width(input int unsigned data_w);
        return data_w + 2;
    endfunction

    // True on the cycle vsync moves into its active level
    function automatic logic vsync_rise(input logic prev, input logic cur, input logic active);
        return (cur == active) && (prev != active);
    endfunction

endpackage

// File: rtl/pyramid_line_buffer.sv
// Simple dual-port line buffer holding horizontal pixel-pair sums of the even line.
// One write port, one registered read port, single clock; contents are not reset.
module pyramid_line_buffer #(
    parameter int unsigned DEPTH = 960,
    parameter int unsigned WIDTH = 9,
    parameter int unsigned A_W   = 10
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [A_W-1:0]   wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [A_W-1:0]   rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rd_data_q;

    // Write port and one-cycle-latency read port
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data_q <= mem[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/pyramid_decimator.sv
// 2x2 block-average decimator for a grey video stream (one pixel per clock).
// Build option: define PYRAMID_ROUND_EN to round the block average to nearest
// instead of truncating it.
module pyramid_decimator
    import pyramid_pkg::*;
#(
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned MAX_WIDTH    = 1920,
    parameter bit          VSYNC_ACTIVE = 1'b1,
    parameter int unsigned X_W          = $clog2(MAX_WIDTH)
) (
    input  logic              rx_pclk,
    input  logic              rst,
    input  logic              in_de,
    input  logic              in_vsync,
    input  logic [DATA_W-1:0] in_pixel,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_pixel,
    output logic [X_W-1:0]    out_x,
    output logic [X_W-1:0]    out_y,
    output logic              out_frame_start,
    output logic              overflow
);

    localparam int unsigned SUM_W  = sum_width(DATA_W);
    localparam int unsigned PAIR_W = DATA_W + 1;
    // Column counter carries one extra bit so it can hold MAX_WIDTH itself
    localparam int unsigned XC_W   = X_W + 1;
    localparam int unsigned DEPTH  = MAX_WIDTH / 2;
    localparam int unsigned A_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [XC_W-1:0] X_MAX = XC_W'(MAX_WIDTH);

    pyr_state_e        state_q, state_d;
    logic              de_q;
    logic              vsync_q;
    logic              line_ok_q, line_ok_d;
    logic [XC_W-1:0]   x_q, x_d;
    logic [X_W-1:0]    y_q, y_d;
    logic [DATA_W-1:0] pix_q, pix_d;
    logic              first_pend_q, first_pend_d;
    logic              overflow_q, overflow_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_pixel_q, out_pixel_d;
    logic [X_W-1:0]    out_x_q, out_x_d;
    logic [X_W-1:0]    out_y_q, out_y_d;
    logic              out_fs_q, out_fs_d;

    logic              frame_start;
    logic              de_rise;
    logic              de_fall;
    logic              line_go;
    logic [XC_W-1:0]   cur_x;
    logic              in_range;
    logic              line_px;
    logic              pix_en;
    logic              even_wr;
    logic              odd_rd;
    logic              emit;
    logic [A_W-1:0]    buf_addr;
    logic [PAIR_W-1:0] pair_sum;
    logic [PAIR_W-1:0] rd_pair;
    logic [SUM_W-1:0]  quad_sum;
    logic [SUM_W-1:0]  quad_adj;
    logic [DATA_W-1:0] avg;

    // Edge detection and per-pixel qualification of the current input beat
    always_comb begin
        frame_start = vsync_rise(vsync_q, in_vsync, VSYNC_ACTIVE);
        de_rise     = in_de & ~de_q;
        de_fall     = ~in_de & de_q;
        // A line is only usable if it started while a frame was in progress
        line_go     = de_rise ? (state_q != WAIT_FRAME) : line_ok_q;
        cur_x       = de_rise ? '0 : x_q;
        in_range    = (cur_x < X_MAX);
        line_px     = in_de && line_go && !frame_start && (state_q != WAIT_FRAME);
        pix_en      = line_px && in_range;
        even_wr     = pix_en && (state_q == EVEN_LINE) && cur_x[0];
        odd_rd      = pix_en && (state_q == ODD_LINE) && !cur_x[0];
        emit        = pix_en && (state_q == ODD_LINE) && cur_x[0];
        buf_addr    = A_W'(cur_x >> 1);
    end

    // Horizontal pair sum, 2x2 block sum and the resulting average
    always_comb begin
        pair_sum = PAIR_W'(pix_q) + PAIR_W'(in_pixel);
        quad_sum = SUM_W'(rd_pair) + SUM_W'(pix_q) + SUM_W'(in_pixel);
`ifdef PYRAMID_ROUND_EN
        // Maximum sum is 2^SUM_W - 4, so adding 2 cannot wrap
        quad_adj = quad_sum + SUM_W'(2);
`else
        quad_adj = quad_sum;
`endif
        avg = DATA_W'(quad_adj >> 2);
    end

    pyramid_line_buffer #(
        .DEPTH (DEPTH),
        .WIDTH (PAIR_W),
        .A_W   (A_W)
    ) u_line_buffer (
        .clk     (rx_pclk),
        .wr_en   (even_wr),
        .wr_addr (buf_addr),
        .wr_data (pair_sum),
        .rd_en   (odd_rd),
        .rd_addr (buf_addr),
        .rd_data (rd_pair)
    );

    // Next-state, counters and output computation
    always_comb begin
        state_d      = state_q;
        x_d          = x_q;
        y_d          = y_q;
        line_ok_d    = line_ok_q;
        pix_d        = pix_q;
        first_pend_d = first_pend_q;
        overflow_d   = overflow_q;
        out_valid_d  = 1'b0;
        out_fs_d     = 1'b0;
        out_pixel_d  = out_pixel_q;
        out_x_d      = out_x_q;
        out_y_d      = out_y_q;

        if (frame_start) begin
            // Frame start wins over everything, including a line in flight
            state_d      = EVEN_LINE;
            x_d          = '0;
            y_d          = '0;
            line_ok_d    = 1'b0;
            overflow_d   = 1'b0;
            first_pend_d = 1'b1;
        end else begin
            if (in_de) begin
                line_ok_d = line_go;
                x_d       = in_range ? (cur_x + XC_W'(1)) : X_MAX;
                if (line_px && !in_range) begin
                    overflow_d = 1'b1;
                end
            end else begin
                line_ok_d = 1'b0;
            end

            // Only lines that began inside the frame advance the line pairing
            if (de_fall && line_ok_q) begin
                case (state_q)
                    EVEN_LINE: state_d = ODD_LINE;
                    ODD_LINE: begin
                        state_d = EVEN_LINE;
                        y_d     = y_q + X_W'(1);
                    end
                    default: state_d = state_q;
                endcase
            end

            if (pix_en) begin
                pix_d = in_pixel;
            end

            if (emit) begin
                out_valid_d  = 1'b1;
                out_pixel_d  = avg;
                out_x_d      = X_W'(cur_x >> 1);
                out_y_d      = y_q;
                out_fs_d     = first_pend_q;
                first_pend_d = 1'b0;
            end
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge rx_pclk) begin
        if (rst) begin
            state_q      <= WAIT_FRAME;
            de_q         <= 1'b0;
            vsync_q      <= VSYNC_ACTIVE;
            line_ok_q    <= 1'b0;
            x_q          <= '0;
            y_q          <= '0;
            pix_q        <= '0;
            first_pend_q <= 1'b0;
            overflow_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            out_pixel_q  <= '0;
            out_x_q      <= '0;
            out_y_q      <= '0;
            out_fs_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            de_q         <= in_de;
            vsync_q      <= in_vsync;
            line_ok_q    <= line_ok_d;
            x_q          <= x_d;
            y_q          <= y_d;
            pix_q        <= pix_d;
            first_pend_q <= first_pend_d;
            overflow_q   <= overflow_d;
            out_valid_q  <= out_valid_d;
            out_pixel_q  <= out_pixel_d;
            out_x_q      <= out_x_d;
            out_y_q      <= out_y_d;
            out_fs_q     <= out_fs_d;
        end
    end

    assign out_valid       = out_valid_q;
    assign out_pixel       = out_pixel_q;
    assign out_x           = out_x_q;
    assign out_y           = out_y_q;
    assign out_frame_start = out_fs_q;
    assign overflow        = overflow_q;

endmodule
